// File: rtl/arm_multicycle_ctrl.sv
// Multi-cycle FSM controller for the ARM-subset datapath.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
`timescale 1ns/1ps
module arm_multicycle_ctrl #(
   parameter int ALUCTRL_W   = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr_i,
   input  logic                 instr_valid_i,
   output logic                 instr_ready_o,
   input  logic [3:0]           alu_flags_i,
   input  logic                 mem_ack_i,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [1:0]           reg_src_o,
   output logic                 reg_write_o,
   output logic [1:0]           imm_src_o,
   output logic                 alu_src_o,
   output logic [ALUCTRL_W-1:0] alu_control_o,
   output logic                 mem_to_reg_o,
   output logic                 pc_src_o,
   output logic                 pc_write_o,
   output logic                 ir_write_o,
   output logic [3:0]           flags_o,
   output logic [2:0]           state_o,
   output logic                 err_o
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [3:0]  flags_q, flags_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [3:0]  cond, cmd, rd;
   logic [1:0]  op;
   logic        immBit, sBit;
   logic        condPass, dpValid, isCmp;
   logic [ALUCTRL_W-1:0] dpCtrl;
   logic        readyInt, irWriteInt;
   logic        unusedIr;

   assign cond     = ir_q[31:28];
   assign op       = ir_q[27:26];
   assign immBit   = ir_q[25];
   assign cmd      = ir_q[24:21];
   assign sBit     = ir_q[20];
   assign rd       = ir_q[15:12];
   assign unusedIr = ^{ir_q[19:16], ir_q[11:0]};

   // Condition check on {N,Z,C,V}; cond=1111 is trapped separately in DECODE.
   always_comb begin
      condPass = 1'b0;
      case (cond)
         4'h0: condPass = flags_q[2];
         4'h1: condPass = ~flags_q[2];
         4'h2: condPass = flags_q[1];
         4'h3: condPass = ~flags_q[1];
         4'h4: condPass = flags_q[3];
         4'h5: condPass = ~flags_q[3];
         4'h6: condPass = flags_q[0];
         4'h7: condPass = ~flags_q[0];
         4'h8: condPass = flags_q[1] & ~flags_q[2];
         4'h9: condPass = ~flags_q[1] | flags_q[2];
         4'hA: condPass = (flags_q[3] == flags_q[0]);
         4'hB: condPass = (flags_q[3] != flags_q[0]);
         4'hC: condPass = ~flags_q[2] & (flags_q[3] == flags_q[0]);
         4'hD: condPass = flags_q[2] | (flags_q[3] != flags_q[0]);
         4'hE: condPass = 1'b1;
         default: condPass = 1'b0;
      endcase
   end

   always_comb begin
      dpValid = 1'b1;
      isCmp   = 1'b0;
      dpCtrl  = '0;
      case (cmd)
         4'b0100: dpCtrl = ALUCTRL_W'(2'd0);
         4'b0010: dpCtrl = ALUCTRL_W'(2'd1);
         4'b0000: dpCtrl = ALUCTRL_W'(2'd2);
         4'b1100: dpCtrl = ALUCTRL_W'(2'd3);
         4'b1010: begin
            dpCtrl = ALUCTRL_W'(2'd1);
            isCmp  = 1'b1;
         end
         4'b0001: begin
            if (ALUCTRL_W >= 3) dpCtrl = ALUCTRL_W'(3'b100);
            else                dpValid = 1'b0;
         end
         default: dpValid = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      flags_d       = flags_q;
      cnt_d         = cnt_q;
      readyInt      = 1'b0;
      irWriteInt    = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      reg_src_o     = 2'b00;
      reg_write_o   = 1'b0;
      imm_src_o     = 2'b00;
      alu_src_o     = 1'b0;
      alu_control_o = '0;
      mem_to_reg_o  = 1'b0;
      pc_src_o      = 1'b0;
      pc_write_o    = 1'b0;
      case (state_q)
         FETCH: begin
            readyInt = 1'b1;
            if (instr_valid_i) begin
               irWriteInt = 1'b1;
               ir_d       = instr_i;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            if (cond == 4'hF || op == 2'b11) begin
               state_d = ERR;
            end else if (!condPass) begin
               pc_write_o = 1'b1;
               state_d    = FETCH;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            case (op)
               2'b00: begin
                  alu_src_o = immBit;
                  if (!dpValid) begin
                     state_d = ERR;
                  end else begin
                     alu_control_o = dpCtrl;
                     if (sBit || isCmp) flags_d = alu_flags_i;
                     if (isCmp) begin
                        pc_write_o = 1'b1;
                        state_d    = FETCH;
                     end else begin
                        state_d = WB;
                     end
                  end
               end
               2'b01: begin
                  imm_src_o = 2'b01;
                  alu_src_o = 1'b1;
                  reg_src_o = sBit ? 2'b00 : 2'b10;
                  state_d   = MEM;
               end
               2'b10: begin
                  imm_src_o  = 2'b10;
                  reg_src_o  = 2'b01;
                  alu_src_o  = 1'b1;
                  pc_src_o   = 1'b1;
                  pc_write_o = 1'b1;
                  state_d    = FETCH;
               end
               default: state_d = ERR;
            endcase
         end
         MEM: begin
            mem_req_o = 1'b1;
            mem_we_o  = ~sBit;
            // An ack arriving on the last allowed cycle still completes the access.
            if (mem_ack_i) begin
               cnt_d = '0;
               if (sBit) begin
                  state_d = WB;
               end else begin
                  pc_write_o = 1'b1;
                  state_d    = FETCH;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == TIMEOUT_LAST) state_d = ERR;
            end
         end
         WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = (op == 2'b01) & sBit;
            pc_src_o     = (rd == 4'hF);
            pc_write_o   = 1'b1;
            state_d      = FETCH;
         end
         ERR: begin
            state_d = ERR;
         end
         default: state_d = ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         ir_q    <= '0;
         flags_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   // The handshake strobes see instr_valid directly, so hold them low while in reset.
   assign instr_ready_o = readyInt & rst_n;
   assign ir_write_o    = irWriteInt & rst_n;
   assign flags_o       = flags_q;
   assign state_o       = state_q;
   assign err_o         = (state_q == ERR);

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Multi-cycle control unit for the ARM-subset DATAPATH. It replaces hand-driven control vectors with an FSM: fetch, decode, execute, memory, writeback. It accepts instructions over a valid/ready handshake and evaluates condition codes against an internal flags register. It drives the existing DATAPATH control inputs, plus PC/IR write enables and a memory request/acknowledge handshake.

Parameters:
ALUCTRL_W, 2, alu_control width; at 3 or more, EOR is also decoded.
MEM_TIMEOUT, 15, maximum cycles spent in MEM without mem_ack before entering ERR; range 1..255.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  32  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  controller accepts instr (FETCH state only)
alu_flags  in  4  {N,Z,C,V} from the DATAPATH ALU
mem_ack  in  1  memory access complete
mem_req  out  1  memory access request
mem_we  out  1  1 = store, 0 = load; valid while mem_req is high
reg_src  out  2  00 data-processing, x1 branch, 10 STR
reg_write  out  1  register file write enable
imm_src  out  2  00 imm8, 01 imm12, 10 imm24
alu_src  out  1  1 = immediate operand B (I bit, or any memory op)
alu_control  out  ALUCTRL_W  00 ADD, 01 SUB, 10 AND, 11 ORR, 100 EOR
mem_to_reg  out  1  writeback source is memory
pc_src  out  1  PC loads the branch target / writeback result
pc_write  out  1  PC update strobe
ir_write  out  1  instruction register load strobe
flags_q  out  4  architectural {N,Z,C,V}
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5
err  out  1  sticky error flag

Behaviour:
- Reset (async, reset=0):
  - state=FETCH; flags_q=0; timeout counter=0; err=0.
  - IR=0; all control outputs 0 immediately, mem_req included.
  - Reset mid-access abandons the access with no writes.
- Decode fields from IR: cond=[31:28], op=[27:26], I=[25], cmd=[24:21], S=[20], L=[20], rd=[15:12].
- Outputs are a Moore/IR decode. Any strobe not listed for a state is 0.
- FETCH:
  - instr_ready=1.
  - On instr_valid: ir_write=1 for one cycle, IR<=instr, go to DECODE. Otherwise stay.
- DECODE:
  - Evaluate cond against flags_q: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - cond=1111 or op=11 -> ERR.
  - Condition fails -> pc_write=1, pc_src=0, go to FETCH. No other side effects.
  - Otherwise go to EXEC.
- EXEC, data-processing (op=00):
  - Decodes ADD 0100, SUB 0010, AND 0000, ORR 1100, and CMP 1010 (SUB with no write).
  - EOR 0001 is decoded only when ALUCTRL_W>=3. Any other cmd -> ERR.
  - imm_src=00, alu_src=I, reg_src=00.
  - If S=1 or CMP: flags_q<=alu_flags at the end of the cycle.
  - CMP then does pc_write=1 and goes to FETCH. All other ops go to WB.
- EXEC, memory (op=01):
  - imm_src=01, alu_src=1, alu_control=00, reg_src=10 when L=0.
  - Go to MEM.
- EXEC, branch (op=10):
  - imm_src=10, reg_src=x1, alu_src=1, alu_control=00.
  - pc_src=1, pc_write=1, go to FETCH.
- MEM:
  - mem_req=1, mem_we=~L. The counter increments each cycle without mem_ack.
  - On mem_ack: clear the counter. Load goes to WB. Store does pc_write=1 and goes to FETCH.
  - Counter reaches MEM_TIMEOUT without ack -> ERR. mem_ack in that same cycle wins.
- WB:
  - reg_write=1, mem_to_reg=L for memory ops (0 otherwise).
  - rd=15: pc_src=1, otherwise pc_src=0. pc_write=1, go to FETCH.
- ERR:
  - err=1 and all strobes 0.
  - Held until reset; instr_ready=0.
- Latency, counted from the accepting FETCH cycle:
  - data-processing 4 cycles; CMP 3; branch 3; condition-fail 2.
  - STR 3+k and LDR 4+k, where k = number of MEM cycles including the ack cycle (k≥1).
- A new instruction is accepted only in FETCH. instr_valid in other states is ignored.

Test Plan:
- ADD 0xE280002A, valid at cycle 0 -> states 0,1,2,4,0; in WB reg_write=1, pc_write=1, pc_src=0; in EXEC alu_control=00, alu_src=1, imm_src=00; flags_q unchanged.
- CMP 0xE3500000 with alu_flags=0100 -> flags_q=0100, reg_write never 1; then BEQ 0x0A000002 -> EXEC has pc_src=1, pc_write=1, imm_src=10; after flags_q=0000, the same BEQ returns to FETCH after DECODE with pc_src=0.
- LDR 0xE5910004, mem_ack on the 3rd MEM cycle -> mem_req high 3 cycles with mem_we=0; WB has mem_to_reg=1, reg_write=1. STR 0xE5810004 -> mem_we=1, reg_src=10, no WB.
- MEM_TIMEOUT=4, STR with mem_ack held 0 -> ERR after 4 MEM cycles, err=1 stays 1, instr_ready=0; a later instr_valid is ignored.
- Undefined 0xEC000000 and EOR 0xE0200001 with ALUCTRL_W=2 -> ERR from DECODE and EXEC respectively; with ALUCTRL_W=3 EOR completes with alu_control=100.
- Reset asserted during MEM of an LDR -> mem_req drops in the same cycle, state=0, flags_q=0, err=0; after release the next ADD completes normally.
